// File: rtl/sweep_learn_ctrl.sv
// sweep_learn_ctrl: steps a generator through a frequency sweep, captures
// the matching FFT bin per point, writes normalised results, learns filter type.
// Ports: clk_50m/rst; start/abort control; fft_* sample input;
// freq/gen_en/fft_start to the front end; wr_* result write port;
// busy/learn_done/filter_type/type_valid/cap_err status.
module sweep_learn_ctrl #(
  parameter int          POINT_NUM    = 64,
  parameter logic [15:0] FREQ_START   = 16'd10,
  parameter logic [15:0] FREQ_STEP    = 16'd40,
  parameter int          SETTLE_CYC   = 149_997,
  parameter int          CAP_TIMEOUT  = 200_000,
  parameter int          DATA_W       = 16,
  parameter int          BLK_EXP_NORM = 8,
  parameter int          EDGE_THRESH  = 500,
  parameter int          ADDR_W       = 6
) (
  input  logic                     clk_50m,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     fft_valid_in,
  input  logic [15:0]              fft_index,
  input  logic signed [DATA_W-1:0] fft_real,
  input  logic signed [DATA_W-1:0] fft_imag,
  input  logic [7:0]               blk_exp,
  output logic [15:0]              freq,
  output logic                     gen_en,
  output logic                     fft_start,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic signed [DATA_W-1:0] wr_real,
  output logic signed [DATA_W-1:0] wr_imag,
  output logic [DATA_W-1:0]        wr_mag,
  output logic                     busy,
  output logic                     learn_done,
  output logic [2:0]               filter_type,
  output logic                     type_valid,
  output logic                     cap_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SETTLE,
    S_CAPTURE,
    S_MAG,
    S_WRITE,
    S_CLASSIFY
  } state_t;

  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
  localparam logic [31:0] CAP_LAST    = 32'(CAP_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_PT = ADDR_W'(POINT_NUM - 1);
  localparam logic [7:0]  NORM = 8'(BLK_EXP_NORM);
  localparam logic [DATA_W:0] THR = (DATA_W+1)'(EDGE_THRESH);
  localparam logic [DATA_W:0] ONE = (DATA_W+1)'(1);

  state_t state, state_nx;

  logic              start_d;
  logic              start_rise;
  logic [31:0]       settle_cnt;
  logic [31:0]       cap_cnt;
  logic [ADDR_W-1:0] point_cnt;
  logic              settle_done;
  logic              cap_to;
  logic              match;
  logic              last_pt;
  logic [7:0]        shamt;

  logic [DATA_W-1:0] ref_mag;
  logic              rise_f;
  logic              fall_f;
  logic [ADDR_W-1:0] rise_idx;
  logic [ADDR_W-1:0] fall_idx;
  logic              is_rise;
  logic              is_fall;
  logic [2:0]        cls;

  logic [DATA_W:0]   re_ext, im_ext;
  logic [DATA_W:0]   re_abs, im_abs;
  logic [DATA_W:0]   mx, mn, mag_sum;
  logic [DATA_W-1:0] mag_sat;
  logic [DATA_W:0]   mag_ext, ref_ext;

  assign start_rise  = start & ~start_d;
  assign settle_done = (settle_cnt == SETTLE_LAST);
  assign cap_to      = (cap_cnt == CAP_LAST);
  assign match       = fft_valid_in && (fft_index == freq);
  assign last_pt     = (point_cnt == LAST_PT);
  assign shamt = (blk_exp >= NORM) ? 8'd0 : (NORM - blk_exp);

  // Magnitude estimate max + min/2, one bit wider so |-2^(W-1)| fits.
  always_comb begin
    re_ext = {wr_real[DATA_W-1], wr_real};
    im_ext = {wr_imag[DATA_W-1], wr_imag};
    re_abs = re_ext[DATA_W] ? (~re_ext + ONE) : re_ext;
    im_abs = im_ext[DATA_W] ? (~im_ext + ONE) : im_ext;
    mx = (re_abs >= im_abs) ? re_abs : im_abs;
    mn = (re_abs >= im_abs) ? im_abs : re_abs;
    mag_sum = mx + (mn >> 1);
    mag_sat = mag_sum[DATA_W] ? {DATA_W{1'b1}}
                              : mag_sum[DATA_W-1:0];
  end

  always_comb begin
    mag_ext = {1'b0, wr_mag};
    ref_ext = {1'b0, ref_mag};
    is_rise = (mag_ext >= ref_ext + THR);
    is_fall = (mag_ext + THR <= ref_ext);
  end

  always_comb begin
    cls = 3'd6;
    unique case (1'b1)
      (rise_f && fall_f && (rise_idx < fall_idx)):  cls = 3'd3;
      (rise_f && fall_f && (rise_idx >= fall_idx)): cls = 3'd4;
      (rise_f && !fall_f):                          cls = 3'd1;
      (!rise_f && fall_f):                          cls = 3'd2;
      default:                                      cls = 3'd6;
    endcase
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = (state != S_IDLE);
    gen_en    = 1'b0;
    fft_start = 1'b0;
    wr_en     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_rise && !abort) state_nx = S_SETUP;
      end
      S_SETUP: begin
        gen_en   = 1'b1;
        state_nx = S_SETTLE;
      end
      S_SETTLE: begin
        gen_en = 1'b1;
        if (settle_done) state_nx = S_CAPTURE;
      end
      S_CAPTURE: begin
        gen_en    = 1'b1;
        fft_start = (cap_cnt == '0);
        if (match || cap_to) state_nx = S_MAG;
      end
      S_MAG: state_nx = S_WRITE;
      S_WRITE: begin
        wr_en    = 1'b1;
        state_nx = last_pt ? S_CLASSIFY : S_SETUP;
      end
      S_CLASSIFY: state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) state_nx = S_IDLE;
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      // Reset as if start were high so a level held through
      // reset release is not taken as a fresh request.
      start_d     <= 1'b1;
      settle_cnt  <= '0;
      cap_cnt     <= '0;
      point_cnt   <= '0;
      freq        <= '0;
      wr_addr     <= '0;
      wr_real     <= '0;
      wr_imag     <= '0;
      wr_mag      <= '0;
      learn_done  <= 1'b0;
      filter_type <= '0;
      type_valid  <= 1'b0;
      cap_err     <= 1'b0;
      ref_mag     <= '0;
      rise_f      <= 1'b0;
      fall_f      <= 1'b0;
      rise_idx    <= '0;
      fall_idx    <= '0;
    end else begin
      start_d    <= start;
      type_valid <= 1'b0;
      // Abort freezes all datapath state; the FSM returns to idle.
      if (!abort) begin
        unique case (state)
          S_IDLE: begin
            if (start_rise) begin
              point_cnt  <= '0;
              freq       <= FREQ_START;
              learn_done <= 1'b0;
              cap_err    <= 1'b0;
            end
          end
          S_SETUP: settle_cnt <= '0;
          S_SETTLE: begin
            if (settle_done) cap_cnt <= '0;
            else settle_cnt <= settle_cnt + 32'd1;
          end
          S_CAPTURE: begin
            if (match) begin
              wr_real <= fft_real >>> shamt;
              wr_imag <= fft_imag >>> shamt;
            end else if (cap_to) begin
              wr_real <= '0;
              wr_imag <= '0;
              cap_err <= 1'b1;
            end else begin
              cap_cnt <= cap_cnt + 32'd1;
            end
          end
          S_MAG: begin
            wr_mag  <= mag_sat;
            wr_addr <= point_cnt;
          end
          S_WRITE: begin
            if (point_cnt == '0) begin
              ref_mag  <= wr_mag;
              rise_f   <= 1'b0;
              fall_f   <= 1'b0;
              rise_idx <= '0;
              fall_idx <= '0;
            end else if (is_rise) begin
              rise_f   <= 1'b1;
              rise_idx <= point_cnt;
              ref_mag  <= wr_mag;
            end else if (is_fall) begin
              fall_f   <= 1'b1;
              fall_idx <= point_cnt;
              ref_mag  <= wr_mag;
            end
            if (!last_pt) begin
              point_cnt <= point_cnt + ADDR_W'(1);
              freq      <= freq + FREQ_STEP;
            end
          end
          S_CLASSIFY: begin
            filter_type <= cls;
            type_valid  <= 1'b1;
            learn_done  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sweep_learn_ctrl.sv
// tb_sweep_learn_ctrl: directed table-driven bench for sweep_learn_ctrl.
// Small sweep (8 points, 20 settle cycles) with a scripted FFT responder.
module tb_sweep_learn_ctrl;

  localparam int PN = 8;
  localparam int ST = 20;
  localparam int CT = 50;

  logic clk_50m = 1'b0;
  logic rst;
  logic start;
  logic abort;
  logic fft_valid_in;
  logic [15:0] fft_index;
  logic signed [15:0] fft_real;
  logic signed [15:0] fft_imag;
  logic [7:0] blk_exp;
  logic [15:0] freq;
  logic gen_en;
  logic fft_start;
  logic wr_en;
  logic [2:0] wr_addr;
  logic signed [15:0] wr_real;
  logic signed [15:0] wr_imag;
  logic [15:0] wr_mag;
  logic busy;
  logic learn_done;
  logic [2:0] filter_type;
  logic type_valid;
  logic cap_err;

  sweep_learn_ctrl #(
    .POINT_NUM(PN),
    .SETTLE_CYC(ST),
    .CAP_TIMEOUT(CT),
    .ADDR_W(3)
  ) dut (
    .clk_50m(clk_50m),
    .rst(rst),
    .start(start),
    .abort(abort),
    .fft_valid_in(fft_valid_in),
    .fft_index(fft_index),
    .fft_real(fft_real),
    .fft_imag(fft_imag),
    .blk_exp(blk_exp),
    .freq(freq),
    .gen_en(gen_en),
    .fft_start(fft_start),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_real(wr_real),
    .wr_imag(wr_imag),
    .wr_mag(wr_mag),
    .busy(busy),
    .learn_done(learn_done),
    .filter_type(filter_type),
    .type_valid(type_valid),
    .cap_err(cap_err)
  );

  always #10 clk_50m = ~clk_50m;

  typedef struct packed {
    logic [7:0][15:0] re;
    logic [7:0][15:0] im;
    logic [7:0][15:0] xre;
    logic [7:0][15:0] xim;
    logic [7:0][15:0] xmag;
    logic [7:0] bexp;
    logic [3:0] skip;
    logic [2:0] ftype;
    logic       cerr;
    logic       rf;
    logic       ff;
    logic [2:0] ridx;
    logic [2:0] fidx;
  } vec_t;

  vec_t tab [6];

  logic signed [15:0] re_tab [8];
  logic signed [15:0] im_tab [8];
  int skip_pt = 15;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // FFT responder: after fft_start, a wrong-bin sample at +2,
  // then the requested bin at +4 (or a wrong bin on skip_pt).
  int fcnt = -1;
  always @(negedge clk_50m) begin
    int pt;
    fft_valid_in = 1'b0;
    fft_index    = 16'hffff;
    fft_real     = '0;
    fft_imag     = '0;
    if (rst) fcnt = -1;
    else if (fft_start) fcnt = 0;
    else if (fcnt >= 0) fcnt = fcnt + 1;
    pt = (int'(freq) - 10) / 40;
    if (pt < 0 || pt > 7) pt = 0;
    if (fcnt == 2) begin
      fft_valid_in = 1'b1;
      fft_index    = freq + 16'd1;
      fft_real     = 16'sd7;
      fft_imag     = 16'sd7;
    end
    if (fcnt == 4) begin
      fft_valid_in = 1'b1;
      fft_index    = (pt == skip_pt) ? freq + 16'd3 : freq;
      fft_real     = re_tab[pt];
      fft_imag     = im_tab[pt];
      fcnt = -1;
    end
  end

  // Monitor: logs every write and timing between key strobes.
  int nwr = 0;
  int cyc = 0;
  int last_fs = 0;
  int last_ge = 0;
  int s2f_last = 0;
  int tv_cyc = 0;
  logic ge_d = 1'b0;
  logic [2:0]         w_addr [256];
  logic [15:0]        w_freq [256];
  logic signed [15:0] w_re   [256];
  logic signed [15:0] w_im   [256];
  logic [15:0]        w_mag  [256];
  int                 w_dist [256];
  int                 w_s2f  [256];

  always @(negedge clk_50m) begin
    cyc++;
    if (gen_en && !ge_d) last_ge = cyc;
    ge_d = gen_en;
    if (fft_start) begin
      last_fs  = cyc;
      s2f_last = cyc - last_ge;
    end
    if (wr_en && nwr < 256) begin
      w_addr[nwr] = wr_addr;
      w_freq[nwr] = freq;
      w_re[nwr]   = wr_real;
      w_im[nwr]   = wr_imag;
      w_mag[nwr]  = wr_mag;
      w_dist[nwr] = cyc - last_fs;
      w_s2f[nwr]  = s2f_last;
      nwr++;
    end
    if (type_valid) tv_cyc++;
  end

  task automatic set_pt(input int s, input int i,
                        input int re, input int im,
                        input int xre, input int xim,
                        input int xmag);
    tab[s].re[i]   = 16'(re);
    tab[s].im[i]   = 16'(im);
    tab[s].xre[i]  = 16'(xre);
    tab[s].xim[i]  = 16'(xim);
    tab[s].xmag[i] = 16'(xmag);
  endtask

  task automatic set_cfg(input int s, input int bexp,
                         input int skip, input int ftype,
                         input int cerr, input int rf,
                         input int ff, input int ridx,
                         input int fidx);
    tab[s].bexp  = 8'(bexp);
    tab[s].skip  = 4'(skip);
    tab[s].ftype = 3'(ftype);
    tab[s].cerr  = 1'(cerr);
    tab[s].rf    = 1'(rf);
    tab[s].ff    = 1'(ff);
    tab[s].ridx  = 3'(ridx);
    tab[s].fidx  = 3'(fidx);
  endtask

  task automatic load(input int s);
    for (int i = 0; i < 8; i++) begin
      re_tab[i] = $signed(tab[s].re[i]);
      im_tab[i] = $signed(tab[s].im[i]);
    end
    blk_exp = tab[s].bexp;
    skip_pt = int'(tab[s].skip);
  endtask

  task automatic wait_tv(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk_50m);
      if (type_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start;
    start = 1'b0;
    @(negedge clk_50m);
    start = 1'b1;
  endtask

  initial begin
    bit ok;
    int base;
    int tvb;
    int nbusy;
    int s1;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    blk_exp = 8'd8;

    for (int i = 0; i < 8; i++) begin
      set_pt(0, i, 1000, 0, 1000, 0, 1000);
      set_pt(2, i, -800, 400, -100, 50, 125);
      set_pt(3, i, 1000, 0, 1000, 0, 1000);
    end
    set_cfg(0, 8, 15, 6, 0, 0, 0, 0, 0);
    set_pt(1, 0, 200, 0, 200, 0, 200);
    set_pt(1, 1, 200, 0, 200, 0, 200);
    set_pt(1, 2, 2000, 0, 2000, 0, 2000);
    set_pt(1, 3, 2000, 0, 2000, 0, 2000);
    set_pt(1, 4, 2000, 0, 2000, 0, 2000);
    set_pt(1, 5, 200, 0, 200, 0, 200);
    set_pt(1, 6, 200, 0, 200, 0, 200);
    set_pt(1, 7, 200, 0, 200, 0, 200);
    set_cfg(1, 8, 15, 3, 0, 1, 1, 2, 5);
    set_cfg(2, 5, 15, 6, 0, 0, 0, 0, 0);
    set_pt(3, 3, 1000, 0, 0, 0, 0);
    set_cfg(3, 8, 3, 4, 1, 1, 1, 4, 3);
    for (int i = 0; i < 4; i++) begin
      set_pt(4, i, 100, 0, 100, 0, 100);
      set_pt(5, i, -32768, -32768, -32768, -32768, 49152);
      set_pt(5, i + 4, 0, 0, 0, 0, 0);
    end
    set_pt(4, 4, 400, -400, 400, -400, 600);
    set_pt(4, 5, 400, -400, 400, -400, 600);
    set_pt(4, 6, 101, 0, 101, 0, 101);
    set_pt(4, 7, 101, 0, 101, 0, 101);
    set_cfg(4, 8, 15, 1, 0, 1, 0, 4, 0);
    set_cfg(5, 10, 15, 2, 0, 0, 1, 0, 4);

    repeat (3) @(negedge clk_50m);
    chk("rst_busy", busy, 0);
    chk("rst_freq", freq, 0);
    chk("rst_gen_en", gen_en, 0);
    chk("rst_filter_type", filter_type, 0);
    chk("rst_learn_done", learn_done, 0);
    chk("rst_wr_en", wr_en, 0);
    rst = 1'b0;
    @(negedge clk_50m);

    for (int s = 0; s < 6; s++) begin
      load(s);
      base = nwr;
      tvb  = tv_cyc;
      pulse_start();
      wait_tv(ok);
      chk($sformatf("s%0d_done", s), ok, 1);
      chk($sformatf("s%0d_learn_done", s), learn_done, 1);
      chk($sformatf("s%0d_filter_type", s),
          filter_type, tab[s].ftype);
      chk($sformatf("s%0d_cap_err", s), cap_err, tab[s].cerr);
      if (tab[s].rf)
        chk($sformatf("s%0d_rise_idx", s), dut.rise_idx,
            tab[s].ridx);
      if (tab[s].ff)
        chk($sformatf("s%0d_fall_idx", s), dut.fall_idx,
            tab[s].fidx);
      start = 1'b0;
      repeat (3) @(negedge clk_50m);
      chk($sformatf("s%0d_tv_cycles", s), tv_cyc - tvb, 1);
      chk($sformatf("s%0d_busy_end", s), busy, 0);
      chk($sformatf("s%0d_nwr", s), nwr - base, PN);
      chk($sformatf("s%0d_settle", s), w_s2f[base], ST + 1);
      for (int i = 0; i < 8; i++) begin
        s1 = base + i;
        chk($sformatf("s%0d_p%0d_addr", s, i), w_addr[s1], i);
        chk($sformatf("s%0d_p%0d_freq", s, i), w_freq[s1],
            10 + 40 * i);
        chk($sformatf("s%0d_p%0d_re", s, i), w_re[s1],
            $signed(tab[s].xre[i]));
        chk($sformatf("s%0d_p%0d_im", s, i), w_im[s1],
            $signed(tab[s].xim[i]));
        chk($sformatf("s%0d_p%0d_mag", s, i), w_mag[s1],
            tab[s].xmag[i]);
        if (i == int'(tab[s].skip))
          chk($sformatf("s%0d_p%0d_timeout", s, i),
              w_dist[s1], CT + 1);
      end
    end

    // Abort in SETTLE of point 4; previous type (2) must survive.
    load(0);
    base = nwr;
    pulse_start();
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk_50m);
      if (nwr - base == 4 && gen_en) begin
        ok = 1'b1;
        break;
      end
    end
    chk("abort_reach_pt4", ok, 1);
    repeat (3) @(negedge clk_50m);
    chk("abort_busy_before", busy, 1);
    abort = 1'b1;
    @(negedge clk_50m);
    chk("abort_busy", busy, 0);
    chk("abort_gen_en", gen_en, 0);
    abort = 1'b0;
    start = 1'b0;
    repeat (100) @(negedge clk_50m);
    chk("abort_nwr", nwr - base, 4);
    chk("abort_learn_done", learn_done, 0);
    chk("abort_filter_type", filter_type, 2);

    // Abort and start edge in the same idle cycle.
    pulse_start();
    abort = 1'b1;
    repeat (2) @(negedge clk_50m);
    chk("abort_start_busy", busy, 0);
    abort = 1'b0;
    repeat (5) @(negedge clk_50m);
    chk("abort_start_after", busy, 0);

    // Reset during CAPTURE with start held high.
    pulse_start();
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_50m);
      if (fft_start) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rst_reach_capture", ok, 1);
    chk("rst_pre_freq", freq, 10);
    rst = 1'b1;
    #1;
    chk("rst_async_freq", freq, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_gen_en", gen_en, 0);
    chk("rst_async_fft_start", fft_start, 0);
    chk("rst_async_wr_mag", wr_mag, 0);
    chk("rst_async_wr_real", wr_real, 0);
    chk("rst_async_wr_imag", wr_imag, 0);
    chk("rst_async_wr_addr", wr_addr, 0);
    chk("rst_async_filter_type", filter_type, 0);
    chk("rst_async_learn_done", learn_done, 0);
    chk("rst_async_cap_err", cap_err, 0);
    @(negedge clk_50m);
    rst = 1'b0;
    nbusy = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_50m);
      if (busy) nbusy++;
    end
    chk("rst_held_start_idle", nbusy, 0);
    base = nwr;
    pulse_start();
    @(negedge clk_50m);
    chk("restart_busy", busy, 1);
    chk("restart_freq", freq, 10);
    wait_tv(ok);
    chk("restart_done", ok, 1);
    chk("restart_filter_type", filter_type, 6);
    chk("restart_nwr", nwr - base, PN);
    start = 1'b0;
    repeat (3) @(negedge clk_50m);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
